vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares one single-port synchronous VRAM bank between the scanline fetch path (BGW/sprite renderer address/data port) and a host command port (CPU/blitter).
- The display path has absolute priority and never stalls.
- Host reads and writes are posted into an in-order command FIFO and drained into idle VRAM cycles, optionally restricted to blanking.
- Sits between the renderers and the VRAM macro, on the pixel clock.

Parameters:
- AW, 15, VRAM address width (words)
- DW, 32, VRAM data width
- FIFO_DEPTH, 4, host command FIFO entries (power of two, ≥2)
- BLANK_ONLY, 0, 1 = host commands issue only while i_de=0
- CW, 16, width of the blocked-cycle statistics counter

Ports:
- i_clk  in  1  pixel clock; all logic is on its rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_de  in  1  display-enable from the timing generator (active video)
- disp_req  in  1  display fetch request this cycle
- disp_addr  in  AW  display fetch address
- disp_q  out  DW  display read data, valid the cycle after disp_req
- host_valid  in  1  host command valid
- host_ready  out  1  FIFO can accept a command
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_rvalid  out  1  host read data valid (one-cycle pulse)
- host_rdata  out  DW  host read data
- mem_en  out  1  VRAM access enable
- mem_we  out  1  VRAM write enable
- mem_addr  out  AW  VRAM address
- mem_wdata  out  DW  VRAM write data
- mem_rdata  in  DW  VRAM read data, registered, 1-cycle latency
- stat_clr  in  1  clear statistics counter
- stat_blocked  out  CW  saturating count of cycles with a pending host command not issued

Behaviour:
- Reset: FIFO empty, all pointers 0, return tag = NONE. Outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, host_rvalid, host_rdata, disp_q, stat_blocked. host_ready = 1 after reset.
- Push: a command is accepted when host_valid && host_ready. host_ready = !full, combinational from the FIFO count. The handshake is valid/ready: host holds all fields stable until accepted.
- Issue (combinational, each cycle), in priority order:
  1. disp_req=1: mem_en=1, mem_we=0, mem_addr=disp_addr; tag<=DISP.
  2. Else if FIFO non-empty and (BLANK_ONLY==0 or i_de==0): pop the head, drive mem_* from it (mem_we=host_we); tag<=HREAD for a read, NONE for a write.
  3. Else: mem_en=0, tag<=NONE.
- No bypass: a command pushed in cycle T issues in T+1 at the earliest.
- Simultaneous push and pop on a non-full FIFO is legal; the count is unchanged.
- Return: tag is registered.
  - tag==DISP: disp_q=mem_rdata, host_rvalid=0.
  - tag==HREAD: host_rvalid=1, host_rdata=mem_rdata. disp_q holds its last display value, registered hold.
- Latency: display read is exactly 1 cycle. Host read is ≥1 cycle after issue, in FIFO order, and is never reordered with writes, so read-after-write returns the new data.
- Blocked-cycle counter:
  - Increments by 1 each cycle the FIFO is non-empty and no pop occurs.
  - Saturates at 2^CW−1.
  - stat_clr has priority over increment and loads 0.
- Full: host_ready=0; host_valid is ignored with no side effect.
- Empty: no pop; mem_en reflects disp_req only.
- Reset asserted mid-operation clears the FIFO and tag immediately. Queued commands are dropped, and a host read in flight produces no host_rvalid.

Decomposition:
- Shared package vram_arb_pkg:
  - tag encoding localparams TAG_NONE=2'd0, TAG_DISP=2'd1, TAG_HREAD=2'd2.
  - host command packing widths: {we, addr, wdata} = 1+AW+DW.
- One sub-module: vram_cmd_fifo, a synchronous FIFO with FIFO_DEPTH entries, push/pop/full/empty/count, async active-low reset.
- Arbitration, tag pipeline and stats stay in the top module.

Test Plan:
- Reset release, no traffic → host_ready=1, mem_en=0, stat_blocked=0, host_rvalid never asserted.
- Host write addr 0x0010 data 0xDEADBEEF, then read 0x0010, disp_req=0 → write issues cycle T+1, read issues T+2, host_rvalid at T+3 with 0xDEADBEEF.
- disp_req held high 10 cycles while host pushes 5 commands (depth 4) → host_ready drops after 4 accepts, no host issue during the 10 cycles, stat_blocked=9 or 10 per the counter rule, disp_q tracks every fetch at 1-cycle latency.
- BLANK_ONLY=1, i_de=1, FIFO holds 2 writes → no issue. Drop i_de to 0 → writes issue in the next two consecutive cycles in order.
- stat_clr pulsed while blocked at count 7 → counter reads 0 next cycle, then resumes counting. With CW=4, forcing 20 blocked cycles → saturates at 15.
- Host read issued, i_rst_n asserted in the next cycle → host_rvalid stays 0, FIFO empty, host_ready=1 after release.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM port arbiter: return-tag encoding and
// host command packing width.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_DISP  = 2'd1,
        TAG_HREAD = 2'd2
    } tag_t;

    // Host command is packed as {we, addr, wdata}.
    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/vram_cmd_fifo.sv
// In-order host command FIFO; power-of-two depth so pointers wrap naturally.
module vram_cmd_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM sharing: display fetches always win, host commands are
// queued and drained into idle cycles (optionally only during blanking).
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW         = 15,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BLANK_ONLY = 0,
    parameter int unsigned CW         = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_de,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_q,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          stat_clr,
    output logic [CW-1:0] stat_blocked
);

    localparam int unsigned CMD_W = cmd_width(AW, DW);

    logic [CMD_W-1:0]              head;
    logic                          head_we;
    logic [AW-1:0]                 head_addr;
    logic [DW-1:0]                 head_wdata;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          push;
    logic                          pop;
    logic                          host_slot;
    tag_t                          tag;
    tag_t                          tag_nxt;
    logic [DW-1:0]                 disp_hold;

    assign host_ready = !full;
    assign push       = host_valid && host_ready;
    assign host_slot  = (BLANK_ONLY == 0) || !i_de;
    assign {head_we, head_addr, head_wdata} = head;

    vram_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .wdata ({host_we, host_addr, host_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pop       = 1'b0;
        tag_nxt   = TAG_NONE;
        if (disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
            tag_nxt  = TAG_DISP;
        end else if (!empty && host_slot) begin
            pop       = 1'b1;
            mem_en    = 1'b1;
            mem_we    = head_we;
            mem_addr  = head_addr;
            mem_wdata = head_wdata;
            tag_nxt   = head_we ? TAG_NONE : TAG_HREAD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag          <= TAG_NONE;
            disp_hold    <= '0;
            stat_blocked <= '0;
        end else begin
            tag <= tag_nxt;
            if (tag == TAG_DISP) disp_hold <= mem_rdata;
            if (stat_clr)
                stat_blocked <= '0;
            else if ((count != '0) && !pop && (stat_blocked != '1))
                stat_blocked <= stat_blocked + 1'b1;
        end
    end

    // Read data arrives one cycle after issue, so returns are steered by the
    // registered tag straight from mem_rdata; disp_q holds between fetches.
    assign disp_q      = (tag == TAG_DISP) ? mem_rdata : disp_hold;
    assign host_rvalid = (tag == TAG_HREAD);
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_vram_port_arbiter;

    localparam int unsigned AW         = 10;
    localparam int unsigned DW         = 32;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned BLANK_ONLY = 1;
    localparam int unsigned CW         = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_de = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_q;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stat_clr = 1'b0;
    logic [CW-1:0] stat_blocked;

    always #5 i_clk = ~i_clk;

    vram_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (DEPTH),
        .BLANK_ONLY (BLANK_ONLY),
        .CW         (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_de         (i_de),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_q       (disp_q),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stat_clr     (stat_clr),
        .stat_blocked (stat_blocked)
    );

    // VRAM macro driven by the DUT; ref_mem is the model's own view.
    logic [DW-1:0] vram    [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    always @(posedge i_clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= vram[mem_addr];
        end
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    cmd_t mq[$];
    cmd_t stim[$];
    logic [DW-1:0] exp_disp = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_rv = 1'b0;
    int            exp_stat = 0;
    bit            accepted = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_disp  = '0;
        exp_rdata = '0;
        exp_rv    = 1'b0;
        exp_stat  = 0;
    endtask

    // Model step at each edge, then the host driver presents the next command.
    always @(posedge i_clk) begin
        int   sz;
        bit   popped;
        cmd_t c;
        if (!i_rst_n) begin
            model_reset();
            accepted = 1'b0;
        end else begin
            sz       = mq.size();
            popped   = 1'b0;
            accepted = host_valid && (sz < DEPTH);
            exp_rv   = 1'b0;
            if (disp_req) begin
                exp_disp = ref_mem[disp_addr];
            end else if (sz > 0 && (BLANK_ONLY == 0 || !i_de)) begin
                c = mq.pop_front();
                popped = 1'b1;
                if (c.we) ref_mem[c.addr] = c.wdata;
                else begin
                    exp_rv    = 1'b1;
                    exp_rdata = ref_mem[c.addr];
                end
            end
            if (stat_clr) exp_stat = 0;
            else if (sz > 0 && !popped && exp_stat < (1 << CW) - 1) exp_stat++;
            if (accepted) mq.push_back(cmd_t'({host_we, host_addr, host_wdata}));
        end
        #2;
        if (accepted && stim.size() > 0) void'(stim.pop_front());
        if (stim.size() > 0) begin
            host_valid = 1'b1;
            {host_we, host_addr, host_wdata} = stim[0];
        end else begin
            host_valid = 1'b0;
        end
    end

    always @(negedge i_clk) begin
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        if (!i_rst_n) model_reset();
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (disp_req) begin
            e_en = 1'b1; e_addr = disp_addr;
        end else if (mq.size() > 0 && (BLANK_ONLY == 0 || !i_de)) begin
            e_en = 1'b1; e_we = mq[0].we; e_addr = mq[0].addr; e_wd = mq[0].wdata;
        end
        chk("host_ready", 64'(host_ready), 64'(mq.size() < DEPTH));
        chk("mem_en", 64'(mem_en), 64'(e_en));
        if (e_en) begin
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        end
        chk("host_rvalid", 64'(host_rvalid), 64'(exp_rv));
        if (exp_rv) chk("host_rdata", 64'(host_rdata), 64'(exp_rdata));
        chk("disp_q", 64'(disp_q), 64'(exp_disp));
        chk("stat_blocked", 64'(stat_blocked), 64'(exp_stat));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
    endtask

    task automatic drain();
        i_de = 1'b0;
        disp_req = 1'b0;
        stat_clr = 1'b0;
        for (int k = 0; k < 100 && (stim.size() != 0 || mq.size() != 0); k++) tick();
        chk("drain_empty", 64'(stim.size() + mq.size()), 64'(0));
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            vram[a]    = 32'hC0DE0000 | 32'(a);
            ref_mem[a] = 32'hC0DE0000 | 32'(a);
        end

        // Reset state and idle after release
        repeat (3) tick();
        at_neg();
        chk("rst_ready", 64'(host_ready), 64'(1));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_rvalid", 64'(host_rvalid), 64'(0));
        chk("rst_rdata", 64'(host_rdata), 64'(0));
        chk("rst_disp_q", 64'(disp_q), 64'(0));
        chk("rst_stat", 64'(stat_blocked), 64'(0));
        tick();
        i_rst_n = 1'b1;
        repeat (4) begin
            at_neg();
            chk("idle_rvalid", 64'(host_rvalid), 64'(0));
            tick();
        end
        at_neg();
        chk("idle_ready", 64'(host_ready), 64'(1));
        chk("idle_mem_en", 64'(mem_en), 64'(0));
        chk("idle_stat", 64'(stat_blocked), 64'(0));

        // Write then read back the same address
        tick();
        stim.push_back(cmd_t'({1'b1, 10'h010, 32'hDEADBEEF}));
        stim.push_back(cmd_t'({1'b0, 10'h010, 32'h0}));
        at_neg();
        chk("wr_nobypass", 64'(mem_en), 64'(0));
        tick();
        at_neg();
        chk("wr_issue_en", 64'(mem_en), 64'(1));
        chk("wr_issue_we", 64'(mem_we), 64'(1));
        chk("wr_issue_addr", 64'(mem_addr), 64'h010);
        chk("wr_issue_data", 64'(mem_wdata), 64'hDEADBEEF);
        tick();
        at_neg();
        chk("rd_issue_en", 64'(mem_en), 64'(1));
        chk("rd_issue_we", 64'(mem_we), 64'(0));
        chk("rd_issue_addr", 64'(mem_addr), 64'h010);
        tick();
        at_neg();
        chk("rd_rvalid", 64'(host_rvalid), 64'(1));
        chk("rd_rdata", 64'(host_rdata), 64'hDEADBEEF);

        // Display owns the port for 10 cycles while the host fills the FIFO
        tick();
        disp_req = 1'b1;
        disp_addr = 10'h020;
        stat_clr = 1'b1;
        for (int k = 0; k < 5; k++) stim.push_back(cmd_t'({1'b1, 10'(10'h050 + k), $urandom()}));
        at_neg();
        chk("disp_en", 64'(mem_en), 64'(1));
        for (int c = 1; c < 10; c++) begin
            tick();
            stat_clr = 1'b0;
            disp_addr = 10'($urandom_range(0, 63));
            at_neg();
            if (c == 1) chk("disp_q_first", 64'(disp_q), 64'hC0DE0020);
            if (c == 3) chk("disp_ready_c3", 64'(host_ready), 64'(1));
            if (c == 4) chk("disp_full", 64'(host_ready), 64'(0));
            chk("disp_no_host", 64'(mem_we), 64'(0));
        end
        tick();
        disp_req = 1'b0;
        at_neg();
        chk("disp_blocked9", 64'(stat_blocked), 64'(9));
        drain();

        // Blanking-only issue
        tick();
        i_de = 1'b1;
        stim.push_back(cmd_t'({1'b1, 10'h030, 32'h11112222}));
        stim.push_back(cmd_t'({1'b1, 10'h031, 32'h33334444}));
        repeat (5) tick();
        at_neg();
        chk("blank_hold_en", 64'(mem_en), 64'(0));
        chk("blank_hold_ready", 64'(host_ready), 64'(1));
        tick();
        i_de = 1'b0;
        at_neg();
        chk("blank_w0_en", 64'(mem_en), 64'(1));
        chk("blank_w0_addr", 64'(mem_addr), 64'h030);
        chk("blank_w0_data", 64'(mem_wdata), 64'h11112222);
        tick();
        at_neg();
        chk("blank_w1_en", 64'(mem_en), 64'(1));
        chk("blank_w1_addr", 64'(mem_addr), 64'h031);
        chk("blank_w1_data", 64'(mem_wdata), 64'h33334444);
        tick();
        at_neg();
        chk("blank_done_en", 64'(mem_en), 64'(0));

        // Statistics clear and saturation
        tick();
        i_de = 1'b1;
        stat_clr = 1'b1;
        stim.push_back(cmd_t'({1'b1, 10'h040, 32'h0BADF00D}));
        tick();
        stat_clr = 1'b0;
        repeat (7) tick();
        stat_clr = 1'b1;
        at_neg();
        chk("stat_at7", 64'(stat_blocked), 64'(7));
        tick();
        stat_clr = 1'b0;
        at_neg();
        chk("stat_cleared", 64'(stat_blocked), 64'(0));
        tick();
        at_neg();
        chk("stat_resume", 64'(stat_blocked), 64'(1));
        repeat (20) tick();
        at_neg();
        chk("stat_sat", 64'(stat_blocked), 64'(15));
        drain();

        // Reset while a host read is in flight
        tick();
        stim.push_back(cmd_t'({1'b0, 10'h030, 32'h0}));
        stim.push_back(cmd_t'({1'b1, 10'h033, 32'h55667788}));
        tick();
        at_neg();
        chk("rstrd_issue_en", 64'(mem_en), 64'(1));
        chk("rstrd_issue_we", 64'(mem_we), 64'(0));
        chk("rstrd_issue_addr", 64'(mem_addr), 64'h030);
        #1;
        i_rst_n = 1'b0;
        stim.delete();
        tick();
        at_neg();
        chk("rstrd_no_rvalid", 64'(host_rvalid), 64'(0));
        tick();
        i_rst_n = 1'b1;
        at_neg();
        chk("rstrd_ready", 64'(host_ready), 64'(1));
        chk("rstrd_mem_en", 64'(mem_en), 64'(0));
        chk("rstrd_rvalid", 64'(host_rvalid), 64'(0));
        tick();
        at_neg();
        chk("rstrd_rvalid2", 64'(host_rvalid), 64'(0));

        // Randomized traffic on a small address window to provoke hazards
        for (int c = 0; c < 1500; c++) begin
            tick();
            disp_req  = ($urandom_range(0, 99) < 35);
            disp_addr = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) i_de = ~i_de;
            stat_clr = ($urandom_range(0, 39) == 0);
            if (stim.size() < 2 && $urandom_range(0, 2) != 0)
                stim.push_back(cmd_t'({1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom()}));
            if ($urandom_range(0, 499) == 0) begin
                at_neg();
                #1;
                i_rst_n = 1'b0;
                stim.delete();
                tick();
                tick();
                i_rst_n = 1'b1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
